jtkunio_ba0_arb: RTL and testbench

//  Shares SDRAM bank 0 between three byte-wide ROM requesters: main CPU, sound CPU and PCM ADPCM fetch.

---
 rtl/jtkunio_ba0_arb_if.sv | 29 ++
 rtl/jtkunio_ba0_arb.sv | 172 +++++++++++++++++
 tb/tb_jtkunio_ba0_arb.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtkunio_ba0_arb_if.sv
// Bank-0 SDRAM read channel between the ROM arbiter and the SDRAM controller.
//   ba0_addr  : word address of the read (arbiter -> controller)
//   ba_rd     : read request, held until ba_ack (arbiter -> controller)
//   ba_ack    : controller accepted the request (controller -> arbiter)
//   ba_rdy    : data_read valid, single-cycle pulse (controller -> arbiter)
//   data_read : 16-bit read word (controller -> arbiter)
interface jtkunio_ba0_arb_if;
  logic [21:0] ba0_addr;
  logic        ba_rd;
  logic        ba_ack;
  logic        ba_rdy;
  logic [15:0] data_read;

  modport master (
    output ba0_addr,
    output ba_rd,
    input  ba_ack,
    input  ba_rdy,
    input  data_read
  );

  modport slave (
    input  ba0_addr,
    input  ba_rd,
    output ba_ack,
    output ba_rdy,
    output data_read
  );
endinterface

// File: rtl/jtkunio_ba0_arb.sv
// Bank-0 SDRAM arbiter for the kunio ROM requesters (main CPU, sound CPU, PCM fetch).
// Each requester owns a one-word cache (tag, valid, 16-bit word). Hits answer combinationally;
// misses are granted round-robin onto a single read channel and fill the cache on ba_rdy.
// Ports:
//   clk, rst_n            : clock and synchronous active-low reset
//   downloading           : blocks new grants and keeps every cache invalid
//   main_/snd_/pcm_cs     : request strobes
//   main_/snd_/pcm_addr   : byte addresses (16/15/17 bits)
//   main_/snd_/pcm_data   : selected byte of the cached word
//   main_/snd_/pcm_ok     : data valid for the current address
//   ba                    : bank-0 read channel (master side)
module jtkunio_ba0_arb #(
  parameter logic [21:0] MAIN_OFFSET = 22'h00000,
  parameter logic [21:0] SND_OFFSET  = 22'h08000,
  parameter logic [21:0] PCM_OFFSET  = 22'h0C000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               downloading,
  input  logic               main_cs,
  input  logic [15:0]        main_addr,
  output logic [7:0]         main_data,
  output logic               main_ok,
  input  logic               snd_cs,
  input  logic [14:0]        snd_addr,
  output logic [7:0]         snd_data,
  output logic               snd_ok,
  input  logic               pcm_cs,
  input  logic [16:0]        pcm_addr,
  output logic [7:0]         pcm_data,
  output logic               pcm_ok,
  jtkunio_ba0_arb_if.master  ba
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  // Requester index: 0 main, 1 sound, 2 PCM.
  state_e      state_q, state_d;
  logic [21:0] addr_q, addr_d;
  logic [15:0] waddr_q, waddr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] tag_q  [3];
  logic [15:0] tag_d  [3];
  logic [15:0] word_q [3];
  logic [15:0] word_d [3];
  logic [2:0]  valid_q, valid_d;

  logic [15:0] req_waddr [3];
  logic [2:0]  cs_vec, hit, miss;
  logic [1:0]  c0, c1, c2, gnt_sel;
  logic        any_miss, start, capture;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [21:0] offset_of(input logic [1:0] i);
    case (i)
      2'd0:    return MAIN_OFFSET;
      2'd1:    return SND_OFFSET;
      default: return PCM_OFFSET;
    endcase
  endfunction

  // Tags are word addresses, zero-extended to a common 16-bit width.
  always_comb begin
    req_waddr[0] = {1'b0, main_addr[15:1]};
    req_waddr[1] = {2'b00, snd_addr[14:1]};
    req_waddr[2] = pcm_addr[16:1];
    cs_vec       = {pcm_cs, snd_cs, main_cs};
    for (int i = 0; i < 3; i++) begin
      hit[i] = valid_q[i] && (tag_q[i] == req_waddr[i]);
    end
    miss = cs_vec & ~hit;
  end

  assign main_ok   = main_cs & hit[0];
  assign snd_ok    = snd_cs  & hit[1];
  assign pcm_ok    = pcm_cs  & hit[2];
  assign main_data = main_addr[0] ? word_q[0][15:8] : word_q[0][7:0];
  assign snd_data  = snd_addr[0]  ? word_q[1][15:8] : word_q[1][7:0];
  assign pcm_data  = pcm_addr[0]  ? word_q[2][15:8] : word_q[2][7:0];

  // ptr_q names the requester with top priority; search wraps from there.
  always_comb begin
    c0       = ptr_q;
    c1       = rr_next(c0);
    c2       = rr_next(c1);
    any_miss = |miss;
    gnt_sel  = c2;
    if (miss[c1]) gnt_sel = c1;
    if (miss[c0]) gnt_sel = c0;
  end

  assign start   = (state_q == StIdle) && !downloading && any_miss;
  // ack and rdy together in REQ complete the transfer without visiting WAIT.
  assign capture = ((state_q == StReq) && ba.ba_ack && ba.ba_rdy) ||
                   ((state_q == StWait) && ba.ba_rdy);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   if (ba.ba_ack) state_d = ba.ba_rdy ? StIdle : StWait;
      StWait:  if (ba.ba_rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Channel outputs.
  always_comb begin
    ba.ba_rd    = (state_q == StReq);
    ba.ba0_addr = addr_q;
  end

  // Grant latch and cache fill.
  always_comb begin
    addr_d  = addr_q;
    waddr_d = waddr_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    word_d  = word_q;
    valid_d = valid_q;
    if (start) begin
      gnt_d   = gnt_sel;
      waddr_d = req_waddr[gnt_sel];
      addr_d  = offset_of(gnt_sel) + {6'd0, req_waddr[gnt_sel]};
    end
    if (capture) begin
      ptr_d = rr_next(gnt_q);
      if (!downloading) begin
        word_d[gnt_q]  = ba.data_read;
        tag_d[gnt_q]   = waddr_q;
        valid_d[gnt_q] = 1'b1;
      end
    end
    // ROM contents may change under download: nothing cached survives it.
    if (downloading) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      waddr_q <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < 3; i++) begin
        tag_q[i]  <= '0;
        word_q[i] <= '0;
      end
    end else begin
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_jtkunio_ba0_arb.sv
// Bench for the bank-0 ROM arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the caches and the round-robin arbiter.
module tb_jtkunio_ba0_arb;

  logic        clk = 1'b0;
  logic        rst_n, downloading;
  logic        main_cs, snd_cs, pcm_cs;
  logic [15:0] main_addr;
  logic [14:0] snd_addr;
  logic [16:0] pcm_addr;
  logic [7:0]  main_data, snd_data, pcm_data;
  logic        main_ok, snd_ok, pcm_ok;

  jtkunio_ba0_arb_if bus ();

  jtkunio_ba0_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .main_cs     (main_cs),
    .main_addr   (main_addr),
    .main_data   (main_data),
    .main_ok     (main_ok),
    .snd_cs      (snd_cs),
    .snd_addr    (snd_addr),
    .snd_data    (snd_data),
    .snd_ok      (snd_ok),
    .pcm_cs      (pcm_cs),
    .pcm_addr    (pcm_addr),
    .pcm_data    (pcm_data),
    .pcm_ok      (pcm_ok),
    .ba          (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  bit          m_busy, m_acked;
  int          m_gnt, m_next, m_waddr;
  logic [21:0] m_addr;
  bit          m_valid [3];
  int          m_tag   [3];
  logic [15:0] m_word  [3];

  function automatic int req_byte(input int i);
    case (i)
      0:       return int'(main_addr);
      1:       return int'(snd_addr);
      default: return int'(pcm_addr);
    endcase
  endfunction

  function automatic bit req_cs(input int i);
    case (i)
      0:       return main_cs;
      1:       return snd_cs;
      default: return pcm_cs;
    endcase
  endfunction

  function automatic int offset(input int i);
    case (i)
      0:       return 'h00000;
      1:       return 'h08000;
      default: return 'h0C000;
    endcase
  endfunction

  function automatic bit m_hit(input int i);
    return m_valid[i] && (m_tag[i] == (req_byte(i) >> 1));
  endfunction

  function automatic logic [7:0] m_data(input int i);
    return ((req_byte(i) & 1) != 0) ? m_word[i][15:8] : m_word[i][7:0];
  endfunction

  task automatic model_step();
    bit cap;
    int i;
    cap = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_acked = 0; m_gnt = 0; m_next = 0; m_waddr = 0; m_addr = '0;
      for (int k = 0; k < 3; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_word[k] = '0;
      end
      return;
    end
    if (m_busy) begin
      if (!m_acked) begin
        if (bus.ba_ack) begin
          if (bus.ba_rdy) cap = 1'b1;
          else            m_acked = 1'b1;
        end
      end else if (bus.ba_rdy) begin
        cap = 1'b1;
      end
    end else if (!downloading) begin
      for (int k = 0; k < 3; k++) begin
        i = (m_next + k) % 3;
        if (req_cs(i) && !m_hit(i)) begin
          m_busy  = 1'b1;
          m_acked = 1'b0;
          m_gnt   = i;
          m_waddr = req_byte(i) >> 1;
          m_addr  = 22'(offset(i) + m_waddr);
          break;
        end
      end
    end
    if (cap) begin
      m_busy = 1'b0;
      if (!downloading) begin
        m_word[m_gnt]  = bus.data_read;
        m_tag[m_gnt]   = m_waddr;
        m_valid[m_gnt] = 1'b1;
      end
      m_next = (m_gnt + 1) % 3;
    end
    if (downloading) for (int k = 0; k < 3; k++) m_valid[k] = 1'b0;
  endtask

  // ---------------- SDRAM responder ----------------
  int          sd_phase = 0;
  int          sd_wait  = 0;
  logic [21:0] sd_addr  = '0;
  int          ack_fix  = -1;
  int          rdy_fix  = -1;

  function automatic logic [15:0] mem(input logic [21:0] a);
    return 16'hA55A ^ {a[7:0], a[15:8]};
  endfunction

  task automatic deliver();
    bus.ba_rdy    = 1'b1;
    bus.data_read = mem(sd_addr);
    sd_phase      = 0;
  endtask

  task automatic sdram_step();
    bus.ba_ack    = 1'b0;
    bus.ba_rdy    = 1'b0;
    bus.data_read = 16'($urandom);
    if (sd_phase == 0 && bus.ba_rd) begin
      sd_phase = 1;
      sd_addr  = bus.ba0_addr;
      sd_wait  = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 4));
    end
    if (sd_phase == 1) begin
      if (sd_wait == 0) begin
        bus.ba_ack = 1'b1;
        sd_wait    = (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(0, 3));
        if (sd_wait == 0) deliver();
        else              sd_phase = 2;
      end else begin
        sd_wait--;
      end
    end else if (sd_phase == 2) begin
      sd_wait--;
      if (sd_wait == 0) deliver();
    end
  endtask

  // ---------------- checking ----------------
  logic [21:0] gq[$];
  bit          prev_rd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic dut_ok(input int i);
    case (i)
      0:       return main_ok;
      1:       return snd_ok;
      default: return pcm_ok;
    endcase
  endfunction

  function automatic logic [7:0] dut_data(input int i);
    case (i)
      0:       return main_data;
      1:       return snd_data;
      default: return pcm_data;
    endcase
  endfunction

  task automatic compare_all();
    chk("ba_rd", 32'(bus.ba_rd), 32'(m_busy && !m_acked));
    chk("ba0_addr", 32'(bus.ba0_addr), 32'(m_addr));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ok[%0d]", i), 32'(dut_ok(i)), 32'(req_cs(i) && m_hit(i)));
      chk($sformatf("data[%0d]", i), 32'(dut_data(i)), 32'(m_data(i)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    sdram_step();
    @(negedge clk);
    if (chk_en) compare_all();
    if (bus.ba_rd && !prev_rd) gq.push_back(bus.ba0_addr);
    prev_rd = bus.ba_rd;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return bus.ba_rd;
      1:       return !bus.ba_rd;
      2:       return main_ok;
      3:       return snd_ok;
      default: return pcm_ok;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int budget, input string name);
    int n;
    n = 0;
    while (!cond(which) && n < budget) begin
      step();
      n++;
    end
    if (!cond(which)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout after %0d cycles, got 0, expected 1", name, budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int dl_cnt = 0;

  initial begin
    rst_n = 1'b0; downloading = 1'b0;
    main_cs = 0; snd_cs = 0; pcm_cs = 0;
    main_addr = '0; snd_addr = '0; pcm_addr = '0;
    bus.ba_ack = 1'b0; bus.ba_rdy = 1'b0; bus.data_read = '0;

    // Reset state.
    step();
    chk_en = 1'b1;
    step();
    chk("reset ba_rd", 32'(bus.ba_rd), 32'd0);
    chk("reset ba0_addr", 32'(bus.ba0_addr), 32'd0);
    chk("reset main_data", 32'(main_data), 32'd0);
    rst_n = 1'b1;

    // Single main fetch of word 0.
    ack_fix = 2; rdy_fix = 1;
    gq.delete();
    main_cs = 1'b1; main_addr = 16'h0001;
    #1 chk("miss main_ok", 32'(main_ok), 32'd0);
    wait_cond(2, 40, "first main fill");
    chk("first main_data", 32'(main_data), 32'h0A5);
    chk("first read count", 32'(gq.size()), 32'd1);
    if (gq.size() > 0) chk("first ba0_addr", 32'(gq[0]), 32'd0);

    // Same-word re-read: hit with zero latency.
    main_addr = 16'h0000;
    #1;
    chk("hit main_ok", 32'(main_ok), 32'd1);
    chk("hit main_data", 32'(main_data), 32'h05A);
    step();
    chk("hit no ba_rd", 32'(bus.ba_rd), 32'd0);

    // Simultaneous misses after reset; main re-misses behind pcm.
    main_cs = 0;
    do_reset();
    ack_fix = -1; rdy_fix = -1;
    gq.delete();
    main_cs = 1; main_addr = 16'h1234;
    snd_cs  = 1; snd_addr  = 15'h0ABC;
    pcm_cs  = 1; pcm_addr  = 17'h1F00F;
    begin
      int n;
      n = 0;
      while (gq.size() < 1 && n < 50) begin step(); n++; end
      main_addr = 16'h4000;
      while (gq.size() < 4 && n < 200) begin step(); n++; end
    end
    chk("grant count", 32'(gq.size()), 32'd4);
    if (gq.size() >= 4) begin
      chk("grant0 main", 32'(gq[0]), 32'h0091A);
      chk("grant1 snd", 32'(gq[1]), 32'h0855E);
      chk("grant2 pcm", 32'(gq[2]), 32'h1B807);
      chk("grant3 main", 32'(gq[3]), 32'h02000);
    end
    wait_cond(2, 60, "main refill");

    // Delayed ack: request held stable.
    ack_fix = 5; rdy_fix = 2;
    snd_addr = 15'h0100;
    wait_cond(0, 20, "delayed ba_rd");
    for (int i = 0; i < 6; i++) begin
      chk("held ba_rd", 32'(bus.ba_rd), 32'd1);
      chk("held ba0_addr", 32'(bus.ba0_addr), 32'h08080);
      step();
    end
    chk("ba_rd after ack", 32'(bus.ba_rd), 32'd0);
    wait_cond(3, 20, "snd fill");

    // Download starts while waiting for data.
    ack_fix = 0; rdy_fix = 4;
    pcm_addr = 17'h00100;
    wait_cond(0, 20, "pcm ba_rd");
    wait_cond(1, 20, "pcm ack");
    downloading = 1'b1;
    main_addr   = 16'h0800;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("dl pcm_ok", 32'(pcm_ok), 32'd0);
      chk("dl no ba_rd", 32'(bus.ba_rd), 32'd0);
    end
    downloading = 1'b0;
    ack_fix = -1; rdy_fix = -1;
    wait_cond(4, 100, "pcm refetch");
    chk("refetch pcm_data", 32'(pcm_data), 32'h09A);
    wait_cond(2, 100, "main after dl");

    // Reset during WAIT followed by a stray ba_rdy.
    ack_fix = 0; rdy_fix = 3;
    snd_addr = 15'h0200;
    wait_cond(0, 40, "snd ba_rd");
    wait_cond(1, 20, "snd ack");
    main_cs = 0; snd_cs = 0; pcm_cs = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post-rst ba_rd", 32'(bus.ba_rd), 32'd0);
    end
    snd_cs = 1; main_cs = 1;
    #1;
    chk("stray snd_ok", 32'(snd_ok), 32'd0);
    chk("stray main_ok", 32'(main_ok), 32'd0);
    step();
    chk("idle regrant", 32'(bus.ba_rd), 32'd1);
    wait_cond(3, 100, "snd after rst");

    // Randomized traffic.
    ack_fix = -1; rdy_fix = -1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0)
        main_addr = 16'(($urandom_range(0, 1) * 'h1000) + $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0)
        snd_addr = 15'(($urandom_range(0, 1) * 'h0800) + $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0)
        pcm_addr = 17'(($urandom_range(0, 1) * 'h10000) + $urandom_range(0, 15));
      main_cs = ($urandom_range(0, 9) != 0);
      snd_cs  = ($urandom_range(0, 9) != 0);
      pcm_cs  = ($urandom_range(0, 9) != 0);
      if (dl_cnt > 0) begin
        dl_cnt--;
        downloading = 1'b1;
      end else begin
        downloading = 1'b0;
        if ($urandom_range(0, 299) == 0) dl_cnt = int'($urandom_range(1, 8));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
